// File: rtl/ffsr_stdp_update_ctrl.sv
// ffsr_stdp_update_ctrl: race-logic STDP update controller for one FFSR.
// Timestamps first pre/post spikes per gamma window, then pulses inc/dec.
module ffsr_stdp_update_ctrl #(
    parameter int N         = 8,
    parameter int GAMMA_LEN = 16,
    parameter int TW        = $clog2(GAMMA_LEN),
    parameter int NEAR      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         gamma_start,
    input  logic         pre_spike,
    input  logic         post_spike,
    input  logic [N-1:0] ffsr_state,
    output logic         inc,
    output logic         incn,
    output logic         dec,
    output logic         decn,
    output logic         busy,
    output logic         upd_done,
    output logic         sat,
    output logic         overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_DECIDE,
        S_PULSE,
        S_SETTLE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_t;
    logic [TW-1:0] r_pre_t;
    logic [TW-1:0] r_post_t;
    logic          r_pre_seen;
    logic          r_post_seen;
    logic          r_dir;
    logic [1:0]    r_steps;
    logic          r_inc;
    logic          r_incn;
    logic          r_dec;
    logic          r_decn;
    logic          r_done;
    logic          r_sat;
    logic          r_ovr;

    logic [TW-1:0] w_delta;
    logic [1:0]    w_steps0;
    logic          w_pot;
    logic          w_dep;
    logic          w_near;
    logic          w_dir;
    logic          w_want;
    logic          w_blk;
    logic          w_fire;
    logic          w_start;
    logic          w_inc_d;
    logic          w_dec_d;
    logic          w_done_d;
    logic          w_sat_d;
    logic          w_ovr_d;
    logic          w_unused;

    // Only the end stages matter for saturation.
    assign w_unused = ^ffsr_state[N-2:1];

    assign w_delta  = r_post_t - r_pre_t;
    assign w_pot    = r_pre_seen && r_post_seen && (r_pre_t <= r_post_t);
    assign w_dep    = r_post_seen && (!r_pre_seen || (r_post_t < r_pre_t));
    assign w_near   = (int'(w_delta) < NEAR);
    assign w_steps0 = (w_pot && w_near) ? 2'd2 : 2'd1;
    assign w_dir    = (r_state == S_DECIDE) ? w_pot : r_dir;
    assign w_want   = ((r_state == S_DECIDE) && (w_pot || w_dep)) ||
                      ((r_state == S_SETTLE) && (r_steps != 2'd0));
    assign w_blk    = w_dir ? ffsr_state[N-1] : ffsr_state[0];
    assign w_fire   = w_want && !w_blk;
    assign w_start  = gamma_start &&
                      ((r_state == S_IDLE) || (r_state == S_CAPTURE));
    assign busy     = (r_state != S_IDLE);

    assign inc      = r_inc;
    assign incn     = r_incn;
    assign dec      = r_dec;
    assign decn     = r_decn;
    assign upd_done = r_done;
    assign sat      = r_sat;
    assign overrun  = r_ovr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (gamma_start) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (gamma_start)
                    w_next = S_CAPTURE;
                else if (r_t == TW'(GAMMA_LEN - 1))
                    w_next = S_DECIDE;
            end
            S_DECIDE, S_SETTLE: begin
                w_next = w_fire ? S_PULSE : S_IDLE;
            end
            S_PULSE: begin
                w_next = S_SETTLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode, registered one cycle later
    always_comb begin
        w_inc_d  = w_fire && w_dir;
        w_dec_d  = w_fire && !w_dir;
        w_done_d = ((r_state == S_DECIDE) || (r_state == S_SETTLE)) && !w_fire;
        w_sat_d  = w_want && w_blk;
        w_ovr_d  = gamma_start && ((r_state == S_DECIDE) ||
                                   (r_state == S_PULSE)  ||
                                   (r_state == S_SETTLE));
    end

    // Output flops; complements kept as separate flops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inc  <= 1'b0;
            r_incn <= 1'b1;
            r_dec  <= 1'b0;
            r_decn <= 1'b1;
            r_done <= 1'b0;
            r_sat  <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_inc  <= w_inc_d;
            r_incn <= ~w_inc_d;
            r_dec  <= w_dec_d;
            r_decn <= ~w_dec_d;
            r_done <= w_done_d;
            r_sat  <= w_sat_d;
            r_ovr  <= w_ovr_d;
        end
    end

    // Spike timestamp capture and remaining-step bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_t         <= '0;
            r_pre_t     <= '0;
            r_post_t    <= '0;
            r_pre_seen  <= 1'b0;
            r_post_seen <= 1'b0;
            r_dir       <= 1'b0;
            r_steps     <= 2'd0;
        end else begin
            if (w_start) begin
                r_pre_seen  <= pre_spike;
                r_post_seen <= post_spike;
                r_pre_t     <= '0;
                r_post_t    <= '0;
                r_t         <= TW'(1);
            end else if (r_state == S_CAPTURE) begin
                if (pre_spike && !r_pre_seen) begin
                    r_pre_seen <= 1'b1;
                    r_pre_t    <= r_t;
                end
                if (post_spike && !r_post_seen) begin
                    r_post_seen <= 1'b1;
                    r_post_t    <= r_t;
                end
                r_t <= r_t + TW'(1);
            end
            if (r_state == S_DECIDE) begin
                r_dir   <= w_pot;
                r_steps <= w_fire ? (w_steps0 - 2'd1) : 2'd0;
            end else if (r_state == S_SETTLE) begin
                r_steps <= w_fire ? (r_steps - 2'd1) : 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_ffsr_stdp_update_ctrl.sv
// tb_ffsr_stdp_update_ctrl: scoreboard bench with a behavioural FFSR.
// Expected per-window results come from a spike-list STDP model.
module tb_ffsr_stdp_update_ctrl;

    localparam int N    = 8;
    localparam int GL   = 16;
    localparam int NEAR = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         gamma_start = 1'b0;
    logic         pre_spike = 1'b0;
    logic         post_spike = 1'b0;
    logic [N-1:0] ffsr;
    logic         ld = 1'b0;
    logic [N-1:0] ld_val = '0;
    logic inc, incn, dec, decn, busy, upd_done, sat, overrun;
    int           cyc = 0;

    ffsr_stdp_update_ctrl #(
        .N(N), .GAMMA_LEN(GL), .TW(4), .NEAR(NEAR)
    ) dut (
        .clk(clk), .rst(rst), .gamma_start(gamma_start),
        .pre_spike(pre_spike), .post_spike(post_spike),
        .ffsr_state(ffsr),
        .inc(inc), .incn(incn), .dec(dec), .decn(decn),
        .busy(busy), .upd_done(upd_done), .sat(sat),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FFSR: one-hot shifts toward N-1 on inc, toward 0 on dec
    always @(posedge clk) begin
        if (ld)       ffsr <= ld_val;
        else if (inc) ffsr <= ffsr << 1;
        else if (dec) ffsr <= ffsr >> 1;
    end

    typedef struct {
        int          st;
        logic [31:0] im;
        logic [31:0] dm;
        int          done;
        logic        sat;
        logic [7:0]  fin;
    } exp_t;

    exp_t        sbq[$];
    int          ovq[$];
    exp_t        me;
    int          n_chk = 0;
    int          n_fail = 0;
    int          stray = 0;
    int          exp_stray = 0;
    logic        mon_en = 1'b0;
    logic        chk_idle = 1'b0;
    logic        chk_end = 1'b0;
    logic [31:0] a_im = '0;
    logic [31:0] a_dm = '0;
    int          m_idx = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] ex);
        n_chk++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, ex, cyc);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on upd_done
    always @(negedge clk) begin
        if (mon_en) begin
            chk("invariants", {inc & dec, incn ^ inc, decn ^ dec,
                               sat & ~upd_done}, 4'b0110);
            if (chk_idle)
                chk("reset_outputs",
                    {inc, incn, dec, decn, busy, upd_done, sat, overrun},
                    8'b0101_0000);
            if (inc || dec) begin
                if (sbq.size() != 0 && (cyc - sbq[0].st) < 32) begin
                    if (inc) a_im[cyc - sbq[0].st] = 1'b1;
                    if (dec) a_dm[cyc - sbq[0].st] = 1'b1;
                end else begin
                    stray++;
                end
            end
            if (upd_done || (sbq.size() != 0 && cyc == sbq[0].done)) begin
                chk("done_pending", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    me = sbq.pop_front();
                    chk("done_cycle", cyc, me.done);
                    chk("upd_done", upd_done, 1);
                    chk("sat", sat, me.sat);
                    chk("inc_cycles", a_im, me.im);
                    chk("dec_cycles", a_dm, me.dm);
                    chk("ffsr_state", ffsr, me.fin);
                    a_im = '0;
                    a_dm = '0;
                end
            end
            if (overrun || (ovq.size() != 0 && cyc == ovq[0])) begin
                chk("ovr_pending", ovq.size() != 0, 1);
                if (ovq.size() != 0) begin
                    chk("ovr_cycle", cyc, ovq[0]);
                    chk("overrun", overrun, 1);
                    void'(ovq.pop_front());
                end
            end
            if (chk_end) begin
                chk("sb_empty", sbq.size(), 0);
                chk("ovq_empty", ovq.size(), 0);
                chk("stray_pulses", stray, exp_stray);
            end
        end
    end

    task automatic drive(input logic g, input logic p, input logic q);
        gamma_start = g;
        pre_spike   = p;
        post_spike  = q;
        @(posedge clk);
        #1;
        ld = 1'b0;
    endtask

    // One window; ovr_at = -2 picks a random overrun offset
    task automatic window(input logic [15:0] pv, input logic [15:0] qv,
                          input int ld_idx, input int junk,
                          input int ovr_at, input int gap);
        exp_t e;
        int fp, fq, dir, steps, idx, np, ov;
        if (ld_idx >= 0) begin
            ld     = 1'b1;
            ld_val = 8'(1) << ld_idx;
            m_idx  = ld_idx;
        end
        for (int k = 0; k < junk; k++) drive(k == 0, k == 2, 1'b0);
        fp = -1;
        fq = -1;
        for (int t = 0; t < GL; t++) begin
            if (pv[t] && fp < 0) fp = t;
            if (qv[t] && fq < 0) fq = t;
        end
        dir   = 0;
        steps = 0;
        if (fp >= 0 && fq >= 0 && fp <= fq) begin
            dir   = 1;
            steps = (fq - fp < NEAR) ? 2 : 1;
        end else if (fq >= 0 && (fp < 0 || fq < fp)) begin
            dir   = -1;
            steps = 1;
        end
        idx   = m_idx;
        np    = 0;
        e.sat = 1'b0;
        e.im  = '0;
        e.dm  = '0;
        for (int k = 0; k < steps; k++) begin
            if (idx + dir < 0 || idx + dir > N - 1) begin
                e.sat = 1'b1;
                break;
            end
            idx = idx + dir;
            if (dir > 0) e.im[GL + 1 + 2 * np] = 1'b1;
            else         e.dm[GL + 1 + 2 * np] = 1'b1;
            np++;
        end
        m_idx = idx;
        e.fin = 8'(1) << idx;
        e.st  = cyc;
        e.done = cyc + GL + 1 + 2 * np;
        sbq.push_back(e);
        ov = ovr_at;
        if (ov == -2) begin
            ov = -1;
            if ($urandom % 3 == 0)
                ov = GL + int'($urandom_range(0, GL + 2 * np));
        end
        for (int t = 0; t < GL; t++) drive(t == 0, pv[t], qv[t]);
        for (int off = GL; off < GL + 1 + 2 * np; off++) begin
            if (off == ov) ovq.push_back(cyc + 1);
            drive(off == ov, 1'($urandom), 1'($urandom));
        end
        for (int g = 0; g < gap; g++)
            drive(1'b0, 1'($urandom), 1'($urandom));
    endtask

    function automatic logic [15:0] rand_spikes();
        logic [15:0] v;
        v = '0;
        if ($urandom % 6 != 0)
            for (int t = 0; t < GL; t++) v[t] = ($urandom % 8 == 0);
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        ld     = 1'b1;
        ld_val = 8'b0000_0001;
        m_idx  = 0;
        repeat (3) @(posedge clk);
        #1;
        ld       = 1'b0;
        rst      = 1'b0;
        mon_en   = 1'b1;
        chk_idle = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk_idle = 1'b0;

        window(16'h0004, 16'h0010, 3, 0, -1, 0);
        window(16'h0002, 16'h0400, -1, 0, -1, 0);
        window(16'h0020, 16'h0008, -1, 0, -1, 1);
        window(16'h0000, 16'h0080, -1, 0, -1, 0);
        window(16'h0080, 16'h0000, -1, 0, -1, 2);
        window(16'h0340, 16'h0040, -1, 0, -1, 0);
        window(16'h0004, 16'h0010, 6, 0, -1, 0);
        window(16'h0000, 16'h0010, 0, 0, -1, 1);
        window(16'h0004, 16'h0010, 2, 0, 18, 0);
        window(16'h0000, 16'h0010, 5, 5, -1, 1);

        for (int t = 0; t < GL; t++) drive(t == 0, t == 2, t == 4);
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        rst       = 1'b0;
        exp_stray = 1;
        m_idx     = m_idx + 1;
        chk_idle  = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk_idle  = 1'b0;
        repeat (6) drive(1'b0, 1'b0, 1'b0);

        repeat (40) begin
            window(rand_spikes(), rand_spikes(),
                   ($urandom % 4 == 0) ? int'($urandom % N) : -1,
                   ($urandom % 8 == 0) ? 1 + int'($urandom % 15) : 0,
                   -2, int'($urandom % 3));
        end

        repeat (5) drive(1'b0, 1'b0, 1'b0);
        chk_end = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk_end = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ffsr_stdp_update_ctrl.md
# ffsr_stdp_update_ctrl

Upstream controller for one FFSR weight register built from the pulse-encoded basic blocks. It timestamps the first pre- and post-synaptic spike in each gamma window and applies a race-logic STDP rule. It emits the mutually exclusive `inc`/`dec` pulses, with true and complement copies, that shift the FFSR's one-hot value. It reads the FFSR state back so the one-hot bit is never shifted off either end.

## Interface
- `N`, 8: FFSR stage count; index 0 is minimum weight, index N-1 is maximum.
- `GAMMA_LEN`, 16: cycles per gamma window, ≥ 2.
- `TW`, 4: timestamp width, equal to $clog2(GAMMA_LEN).
- `NEAR`, 4: potentiation delta below which 2 steps are applied instead of 1.
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `gamma_start`  in  1  1-cycle pulse; that cycle is t=0 of a new window.
- `pre_spike`  in  1  pre-synaptic spike, sampled every cycle.
- `post_spike`  in  1  post-synaptic spike, sampled every cycle.
- `ffsr_state`  in  N  registered one-hot outputs of the FFSR stages.
- `inc` / `incn`  out  1  increment pulse and its complement.
- `dec` / `decn`  out  1  decrement pulse and its complement.
- `busy`  out  1  high in every state except IDLE.
- `upd_done`  out  1  1-cycle pulse when the update for a window completes.
- `sat`  out  1  1-cycle pulse, coincident with `upd_done`, when steps were dropped at an FFSR end.
- `overrun`  out  1  1-cycle pulse when `gamma_start` is ignored.

## Operation
- FSM states: IDLE, CAPTURE, DECIDE, PULSE, SETTLE.
- IDLE with `gamma_start`:
  - clear `pre_seen`, `post_seen` and the timestamps;
  - record any spike present this cycle with t=0;
  - set t=1 and go to CAPTURE.
- CAPTURE:
  - only the first pre spike and the first post spike are recorded (`pre_t`, `post_t`); later spikes are ignored;
  - t increments every cycle;
  - after the cycle with t=GAMMA_LEN-1, go to DECIDE;
  - `gamma_start` in CAPTURE restarts the window exactly as from IDLE, and the old window is discarded.
- DECIDE (1 cycle) applies the rule:
  - pre_seen && post_seen && pre_t ≤ post_t: potentiate. delta = post_t − pre_t (TW-bit unsigned, never negative). steps = 2 if delta < NEAR, else 1.
  - post_seen && (!pre_seen || post_t < pre_t): depress, steps = 1.
  - Otherwise no change: go to IDLE and assert `upd_done` next cycle.
- Saturation check (in DECIDE and in every SETTLE, before each pulse), using the current `ffsr_state`:
  - potentiation blocked if `ffsr_state[N-1]`=1;
  - depression blocked if `ffsr_state[0]`=1;
  - if blocked, drop the remaining steps, go to IDLE, and pulse `sat` together with `upd_done`.
- Otherwise register the pulse (`inc` or `dec` high) for the PULSE cycle, then go to SETTLE with steps decremented.
- SETTLE: no pulse is driven. If steps remain, run the saturation check and issue the next pulse; otherwise go to IDLE.
- Invariants, every cycle:
  - `inc` & `dec` = 0;
  - `incn` = ~`inc` and `decn` = ~`dec`, all four from flops.
- `gamma_start` in DECIDE, PULSE or SETTLE is ignored and `overrun` pulses the next cycle.
- Reset (any state):
  - next cycle: IDLE, `inc`=`dec`=0, `incn`=`decn`=1, `busy`=`upd_done`=`sat`=`overrun`=0;
  - timestamps, flags, t and steps cleared;
  - any in-flight pulse sequence is aborted with no further pulses.

## Timing
- Window = GAMMA_LEN cycles counted from the `gamma_start` cycle (cycle 0); DECIDE is in cycle GAMMA_LEN.
- Pulses are 1 cycle wide with at least 1 idle cycle between them. First pulse at cycle GAMMA_LEN+1, second at GAMMA_LEN+3.
- The FFSR registers a pulse at the following edge, so SETTLE sees the updated `ffsr_state`.
- `upd_done` fires in the first IDLE cycle:
  - GAMMA_LEN+1 for no change or saturation in DECIDE;
  - GAMMA_LEN+3 for 1 step;
  - GAMMA_LEN+5 for 2 steps.
- `busy` is high from cycle 1 through the last SETTLE.
- Back-to-back windows: `gamma_start` is accepted in the `upd_done` cycle.

## Test plan
All scenarios use N=8, GAMMA_LEN=16, NEAR=4, with a behavioural FFSR model.
- Reset with `ffsr_state`=8'b0000_1000, `gamma_start`@0, pre@t2, post@t4 -> `inc` high in cycles 17 and 19 only, `upd_done`@21, model state 8'b0010_0000, `sat`=0.
- pre@t1, post@t10 (delta 9) -> single `inc`@17, `upd_done`@19; separate run with post@t3, pre@t5 -> single `dec`@17; post-only -> `dec`@17; pre-only -> no pulse, `upd_done`@17.
- pre and post both @t6, extra pre spikes @t8 and @t9 -> treated as delta 0: 2 `inc` pulses, extra spikes ignored.
- `ffsr_state`=8'b0100_0000 with a 2-step potentiation -> `inc`@17 only; `upd_done`+`sat`@19; state 8'b1000_0000. Same with 8'b0000_0001 and a depression -> no `dec`, `upd_done`+`sat`@17.
- `gamma_start`@18 (SETTLE) -> `overrun`@19, window not started; `gamma_start`@5 in CAPTURE -> window restarts and pre@t2 of the old window is discarded.
- `rst` asserted in cycle 17 (PULSE) -> cycle 18: `inc`=0, `incn`=1, `busy`=0, no `upd_done`; throughout all runs, `inc`&`dec` never 1 and the complements always match.
